// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the GPIO bus master.
//   GPIO_ADDR_*  : register map of the GPIO peripheral
//   gpio_state_e : bus master FSM state encoding
package gpio_pkg;

   localparam logic [1:0] GPIO_ADDR_BTN  = 2'd0;
   localparam logic [1:0] GPIO_ADDR_LED  = 2'd1;
   localparam logic [1:0] GPIO_ADDR_HEX0 = 2'd2;
   localparam logic [1:0] GPIO_ADDR_HEX1 = 2'd3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR     = 3'd1,
      RD     = 3'd2,
      RWAIT  = 3'd3,
      RSP    = 3'd4,
      P_RD   = 3'd5,
      P_WAIT = 3'd6,
      P_CLR  = 3'd7
   } gpio_state_e;

endpackage

// File: rtl/gpio_bus_master_if.sv
// gpio_bus_master_if: register port of the GPIO peripheral.
//   addr  : register address
//   wr_en : write strobe, data taken at the edge ending the cycle
//   rd_en : read strobe, rdata valid the following cycle
//   wdata : write data
//   rdata : registered read data from the peripheral
// Modports: master (bus initiator), slave (peripheral).
interface gpio_bus_master_if #(
   parameter int DATA_W = 32
);
   logic [1:0]        addr;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;

   modport master (output addr, output wr_en, output rd_en, output wdata, input rdata);
   modport slave  (input addr, input wr_en, input rd_en, input wdata, output rdata);
endinterface

// File: rtl/gpio_poll_timer.sv
// gpio_poll_timer: poll prescaler.
//   clk, reset_n : clock, async active-low reset
//   en           : count enable; low holds the counter at 0
//   tick         : high during the terminal-count cycle (count DIV-1)
module gpio_poll_timer #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] TC = W'(DIV - 1);

   logic [W-1:0] cnt;

   assign tick = en && (cnt == TC);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (!en || (cnt == TC)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/gpio_bus_master.sv
// gpio_bus_master: sole initiator on the GPIO register bus.
//   clk, reset_n       : clock, async active-low reset
//   cmd_*              : host command channel (valid/ready handshake)
//   rsp_valid/rdata    : one-cycle completion pulse, read data (0 for writes)
//   poll_en            : enables periodic polling of the button flags
//   btn_event/status   : pulse and captured flags when a poll saw presses
//   bus                : peripheral register port (master modport)
//
// state  | meaning
// IDLE   | waiting; a pending poll beats the host
// WR     | host write strobe on the bus
// RD     | host read strobe on the bus
// RWAIT  | peripheral read data valid, captured into rsp_rdata
// RSP    | rsp_valid pulse
// P_RD   | poll read of the button register
// P_WAIT | button flags valid, decide whether to clear
// P_CLR  | clear flags, report btn_event
module gpio_bus_master
   import gpio_pkg::*;
#(
   parameter int POLL_DIV = 50000,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [1:0]        cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   input  logic              poll_en,
   output logic              btn_event,
   output logic [3:0]        btn_status,
   gpio_bus_master_if.master bus
);
   localparam logic [2:0] ST_IDLE   = IDLE;
   localparam logic [2:0] ST_WR     = WR;
   localparam logic [2:0] ST_RD     = RD;
   localparam logic [2:0] ST_RWAIT  = RWAIT;
   localparam logic [2:0] ST_RSP    = RSP;
   localparam logic [2:0] ST_P_RD   = P_RD;
   localparam logic [2:0] ST_P_WAIT = P_WAIT;
   localparam logic [2:0] ST_P_CLR  = P_CLR;

   logic [2:0] state;
   logic       poll_pending;
   logic       tick;

   gpio_poll_timer #(.DIV(POLL_DIV)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (poll_en),
      .tick    (tick)
   );

   assign cmd_ready = (state == ST_IDLE) && !poll_pending;

   // Pending is cleared while the poll read is on the bus, so a tick landing
   // in P_RD is dropped rather than queued behind the running poll.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         poll_pending <= 1'b0;
      end else if (!poll_en || (state == ST_P_RD)) begin
         poll_pending <= 1'b0;
      end else if (tick) begin
         poll_pending <= 1'b1;
      end
   end

   // Bus outputs are registered on entry to the strobe state, so the bus
   // registers themselves hold the captured command for WR/RD.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         bus.addr   <= 2'd0;
         bus.wr_en  <= 1'b0;
         bus.rd_en  <= 1'b0;
         bus.wdata  <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         btn_event  <= 1'b0;
         btn_status <= 4'd0;
      end else begin
         bus.addr  <= 2'd0;
         bus.wr_en <= 1'b0;
         bus.rd_en <= 1'b0;
         bus.wdata <= '0;
         rsp_valid <= 1'b0;
         btn_event <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (poll_pending) begin
                  state     <= ST_P_RD;
                  bus.rd_en <= 1'b1;
                  bus.addr  <= GPIO_ADDR_BTN;
               end else if (cmd_valid) begin
                  bus.addr <= cmd_addr;
                  if (cmd_write) begin
                     state     <= ST_WR;
                     bus.wr_en <= 1'b1;
                     bus.wdata <= cmd_wdata;
                  end else begin
                     state     <= ST_RD;
                     bus.rd_en <= 1'b1;
                  end
               end
            end
            ST_WR: begin
               state     <= ST_RSP;
               rsp_valid <= 1'b1;
               rsp_rdata <= '0;
            end
            ST_RD: begin
               state <= ST_RWAIT;
            end
            ST_RWAIT: begin
               state     <= ST_RSP;
               rsp_valid <= 1'b1;
               rsp_rdata <= bus.rdata;
            end
            ST_RSP: begin
               state <= ST_IDLE;
            end
            ST_P_RD: begin
               state <= ST_P_WAIT;
            end
            ST_P_WAIT: begin
               if (bus.rdata[3:0] != 4'd0) begin
                  state      <= ST_P_CLR;
                  bus.wr_en  <= 1'b1;
                  bus.addr   <= GPIO_ADDR_BTN;
                  btn_event  <= 1'b1;
                  btn_status <= bus.rdata[3:0];
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_P_CLR: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_gpio_bus_master.sv
// tb_gpio_bus_master: scoreboard bench for gpio_bus_master with POLL_DIV=8
// and a behavioural GPIO peripheral model.
module tb_gpio_bus_master;
   import gpio_pkg::*;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_write = 1'b0;
   logic [1:0]    cmd_addr = 2'd0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          poll_en = 1'b0;
   logic          cmd_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          btn_event;
   logic [3:0]    btn_status;

   always #5 clk = ~clk;

   gpio_bus_master_if #(.DATA_W(DW)) bus_if ();

   gpio_bus_master #(.POLL_DIV(8), .DATA_W(DW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .poll_en    (poll_en),
      .btn_event  (btn_event),
      .btn_status (btn_status),
      .bus        (bus_if)
   );

   // Peripheral model: registered read data, sticky button flags in reg 0.
   logic [DW-1:0] regs [4];
   logic          model_rst = 1'b1;
   logic [3:0]    btn_press = 4'd0;

   always @(posedge clk) begin
      if (model_rst) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
         bus_if.rdata <= '0;
      end else begin
         if (btn_press != 4'd0) regs[0][3:0] <= regs[0][3:0] | btn_press;
         if (bus_if.wr_en) regs[bus_if.addr] <= bus_if.wdata;
         if (bus_if.rd_en) bus_if.rdata <= regs[bus_if.addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected output 0x%08h with nothing expected (t=%0t)", name, act, $time);
   endtask

   typedef struct packed {
      logic          wr;
      logic [1:0]    addr;
      logic [DW-1:0] data;
   } bus_op_t;

   typedef struct {
      logic [DW-1:0] rdata;
      int            e0;
      int            k;
   } rsp_t;

   bus_op_t    exp_bus[$];
   rsp_t       exp_rsp[$];
   logic [3:0] exp_btn[$];

   function automatic bus_op_t mk_op(input logic wr, input logic [1:0] a, input logic [DW-1:0] d);
      bus_op_t op;
      op.wr   = wr;
      op.addr = a;
      op.data = d;
      return op;
   endfunction

   // Monitor: pops expectations whenever the DUT presents something.
   always @(negedge clk) begin
      bus_op_t op;
      rsp_t    r;
      logic [3:0] b;
      if (bus_if.wr_en && bus_if.rd_en) begin
         check("bus_overlap", 32'({bus_if.wr_en, bus_if.rd_en}), 32'h1);
      end else if (bus_if.wr_en || bus_if.rd_en) begin
         if (exp_bus.size() == 0) begin
            unexpected("bus_op", 32'({bus_if.wr_en, bus_if.addr}));
         end else begin
            op = exp_bus.pop_front();
            check("bus_wr", 32'(bus_if.wr_en), 32'(op.wr));
            check("bus_addr", 32'(bus_if.addr), 32'(op.addr));
            if (op.wr) check("bus_wdata", bus_if.wdata, op.data);
         end
      end else begin
         check("bus_idle", 32'(bus_if.addr) | bus_if.wdata, 32'h0);
      end
      if (rsp_valid) begin
         if (exp_rsp.size() == 0) begin
            unexpected("rsp", rsp_rdata);
         end else begin
            r = exp_rsp.pop_front();
            check("rsp_rdata", rsp_rdata, r.rdata);
            // during cycle E0+k the counter reads e0+k-1
            check("rsp_latency", 32'(cyc - r.e0 + 1), 32'(r.k));
         end
      end
      if (btn_event) begin
         if (exp_btn.size() == 0) begin
            unexpected("btn_event", 32'(btn_status));
         end else begin
            b = exp_btn.pop_front();
            check("btn_status", 32'(btn_status), 32'(b));
         end
      end
   end

   // Issues one command; e0 is the counter value just after the handshake edge.
   task automatic do_cmd(input logic wr, input logic [1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp_rd, input bit want_rsp, input bit hold,
                         output int e0);
      rsp_t r;
      int   t;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      exp_bus.push_back(mk_op(wr, a, wr ? d : '0));
      t = 0;
      while (!cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("cmd_ready_wait", 32'(cmd_ready), 32'h1);
      @(posedge clk);
      #1;
      e0 = cyc;
      if (!hold) cmd_valid = 1'b0;
      if (want_rsp) begin
         r.rdata = exp_rd;
         r.e0    = e0;
         r.k     = wr ? 2 : 3;
         exp_rsp.push_back(r);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
      check({tag, "_btn"}, 32'({btn_event, btn_status}), 32'h0);
      check({tag, "_bus_en"}, 32'({bus_if.wr_en, bus_if.rd_en}), 32'h0);
      check({tag, "_bus_addr"}, 32'(bus_if.addr), 32'h0);
      check({tag, "_bus_wdata"}, bus_if.wdata, 32'h0);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
   endtask

   initial begin
      int e0;
      int t;

      // Reset, with a command presented that must be ignored.
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = GPIO_ADDR_LED;
      cmd_wdata = 32'hFFFF;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      model_rst = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // Write LED register.
      do_cmd(1'b1, GPIO_ADDR_LED, 32'h0002_ABCD, 32'h0, 1'b1, 1'b0, e0);
      @(negedge clk);
      check("wr_en_e1", 32'(bus_if.wr_en), 32'h1);
      check("wr_ready_e1", 32'(cmd_ready), 32'h0);
      @(negedge clk);
      check("wr_en_e2", 32'(bus_if.wr_en), 32'h0);
      check("wr_rsp_e2", 32'(rsp_valid), 32'h1);
      @(negedge clk);
      check("wr_ready_e3", 32'(cmd_ready), 32'h1);
      check("model_reg1", regs[1], 32'h0002_ABCD);

      // Preset HEX0, then read it back.
      do_cmd(1'b1, GPIO_ADDR_HEX0, 32'h5A, 32'h0, 1'b1, 1'b0, e0);
      do_cmd(1'b0, GPIO_ADDR_HEX0, 32'h0, 32'h5A, 1'b1, 1'b0, e0);
      @(negedge clk);
      check("rd_en_e1", 32'(bus_if.rd_en), 32'h1);
      check("rd_ready_e1", 32'(cmd_ready), 32'h0);
      @(negedge clk);
      check("rd_ready_e2", 32'(cmd_ready), 32'h0);
      @(negedge clk);
      check("rd_ready_e3", 32'(cmd_ready), 32'h0);
      check("rd_rsp_e3", 32'(rsp_valid), 32'h1);
      @(negedge clk);
      check("rd_ready_e4", 32'(cmd_ready), 32'h1);

      do_cmd(1'b1, GPIO_ADDR_HEX1, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, e0);
      repeat (3) @(negedge clk);

      // Poll with a pressed button.
      btn_press = 4'b0100;
      @(negedge clk);
      btn_press = 4'd0;
      check("model_reg0_set", regs[0], 32'h4);
      exp_bus.push_back(mk_op(1'b0, GPIO_ADDR_BTN, '0));
      exp_bus.push_back(mk_op(1'b1, GPIO_ADDR_BTN, '0));
      exp_btn.push_back(4'b0100);
      poll_en = 1'b1;
      t = 0;
      while (!btn_event && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("btn_event_seen", 32'(btn_event), 32'h1);
      poll_en = 1'b0;
      repeat (3) @(negedge clk);
      check("model_reg0_clr", regs[0], 32'h0);

      // Poll with no flags: read only, status unchanged.
      exp_bus.push_back(mk_op(1'b0, GPIO_ADDR_BTN, '0));
      poll_en = 1'b1;
      t = 0;
      while (!bus_if.rd_en && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("poll_rd_seen", 32'(bus_if.rd_en), 32'h1);
      repeat (3) @(negedge clk);
      poll_en = 1'b0;
      check("btn_status_kept", 32'(btn_status), 32'h4);
      repeat (2) @(negedge clk);

      // Contention: back-to-back reads with cmd_valid held across a tick.
      // The tick lands during the second read; the poll runs before the third.
      poll_en = 1'b1;
      do_cmd(1'b0, GPIO_ADDR_LED, '0, 32'h0002_ABCD, 1'b1, 1'b1, e0);
      do_cmd(1'b0, GPIO_ADDR_HEX0, '0, 32'h5A, 1'b1, 1'b1, e0);
      exp_bus.push_back(mk_op(1'b0, GPIO_ADDR_BTN, '0));
      do_cmd(1'b0, GPIO_ADDR_HEX1, '0, 32'hDEAD_BEEF, 1'b1, 1'b0, e0);
      poll_en = 1'b0;
      repeat (6) @(negedge clk);

      // Reset during RWAIT aborts the read with no response.
      do_cmd(1'b0, GPIO_ADDR_HEX0, '0, '0, 1'b0, 1'b0, e0);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      do_cmd(1'b0, GPIO_ADDR_HEX0, '0, 32'h5A, 1'b1, 1'b0, e0);
      repeat (8) @(negedge clk);

      check("exp_bus_drained", 32'(exp_bus.size()), 32'h0);
      check("exp_rsp_drained", 32'(exp_rsp.size()), 32'h0);
      check("exp_btn_drained", 32'(exp_btn.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
